// File: rtl/decoder_2to4_pkg.sv
// rtl/decoder_2to4_pkg.sv - widths, one-hot type and decode helper for decoder_2to4
// Idle/reset output value depends on macro DECODER_2TO4_ACTIVE_LOW_EN.
package decoder_2to4_pkg;

    localparam int IN_W  = 2;
    localparam int OUT_W = 4;

    typedef logic [OUT_W-1:0] onehot_t;

`ifdef DECODER_2TO4_ACTIVE_LOW_EN
    localparam onehot_t OUT_IDLE = '1;
`else
    localparam onehot_t OUT_IDLE = '0;
`endif

    function automatic onehot_t dec2to4(logic [IN_W-1:0] code);
        return onehot_t'(1) << code;
    endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// rtl/decoder_2to4_core.sv - combinational select decode with output polarity applied
// Polarity is inverted when macro DECODER_2TO4_ACTIVE_LOW_EN is defined.
module decoder_2to4_core
    import decoder_2to4_pkg::*;
(
    input  logic [IN_W-1:0] i_code,
    input  logic            i_en,
    output onehot_t         o_onehot,
    output logic            o_valid
);

    onehot_t w_hot;
    logic    w_valid;

    // Only fully known codes decode; X/Z falls to the default so downstream selects stay quiet.
    always_comb begin
        w_hot   = '0;
        w_valid = 1'b0;
        if (i_en) begin
            case (i_code)
                2'b00, 2'b01, 2'b10, 2'b11: begin
                    w_hot   = dec2to4(i_code);
                    w_valid = 1'b1;
                end
                default: begin
                    w_hot   = '0;
                    w_valid = 1'b0;
                end
            endcase
        end
    end

`ifdef DECODER_2TO4_ACTIVE_LOW_EN
    assign o_onehot = ~w_hot;
`else
    assign o_onehot = w_hot;
`endif
    assign o_valid  = w_valid;

endmodule

// File: rtl/decoder_2to4.sv
// rtl/decoder_2to4.sv - 2-to-4 one-hot decoder with enable and optional output register
// Output polarity selected by macro DECODER_2TO4_ACTIVE_LOW_EN; REG_OUT picks registered or combinational.
module decoder_2to4
    import decoder_2to4_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] in,
    input  logic            en,
    output logic [OUT_W-1:0] out,
    output logic            out_valid
);

    onehot_t w_core_out;
    logic    w_core_valid;

    decoder_2to4_core u_core (
        .i_code   (in),
        .i_en     (en),
        .o_onehot (w_core_out),
        .o_valid  (w_core_valid)
    );

    generate
        if (REG_OUT) begin : g_reg
            onehot_t r_out;
            logic    r_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out   <= OUT_IDLE;
                    r_valid <= 1'b0;
                end else begin
                    r_out   <= w_core_out;
                    r_valid <= w_core_valid;
                end
            end

            assign out       = r_out;
            assign out_valid = r_valid;
        end else begin : g_comb
            assign out       = w_core_out;
            assign out_valid = w_core_valid;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_2to4.sv
// tb/tb_decoder_2to4.sv - self-checking bench for decoder_2to4 (registered and combinational builds)
module tb_decoder_2to4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] r_in = 2'd0;
    logic       r_en = 1'b0;
    logic [3:0] w_out;
    logic       w_valid;

    logic [1:0] c_in = 2'd0;
    logic       c_en = 1'b0;
    logic [3:0] c_out;
    logic       c_valid;

    int n_vec = 0;
    int n_err = 0;

    decoder_2to4 #(.REG_OUT(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (r_in),
        .en        (r_en),
        .out       (w_out),
        .out_valid (w_valid)
    );

    decoder_2to4 #(.REG_OUT(1'b0)) dut_comb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (c_in),
        .en        (c_en),
        .out       (c_out),
        .out_valid (c_valid)
    );

    always #5 clk = ~clk;

    // Reference: selected position is 2**code; disabled means nothing selected.
    function automatic logic [3:0] model_out(int code, bit e);
        logic [3:0] v;
        v = e ? 4'(2 ** code) : 4'd0;
`ifdef DECODER_2TO4_ACTIVE_LOW_EN
        v = ~v;
`endif
        return v;
    endfunction

    function automatic logic [3:0] idle_out();
        return model_out(0, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] code, input logic e, input string tag);
        @(negedge clk);
        r_in = code;
        r_en = e;
        @(posedge clk);
        #1;
        chk({tag, "_out"}, w_out, model_out(int'(code), e));
        chk({tag, "_valid"}, {3'b0, w_valid}, {3'b0, e});
    endtask

    initial begin
        // Reset with no clock edge: pull rst_n low before the first posedge at t=5.
        r_in = 2'b11;
        r_en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out", w_out, idle_out());
        chk("reset_valid", {3'b0, w_valid}, 4'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) step(2'(i), 1'b1, "sweep");

        step(2'b10, 1'b0, "en_low");
        step(2'b10, 1'b1, "en_high");

        step(2'b01, 1'b1, "stream_a");
        step(2'b01, 1'b1, "stream_b");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", w_out, idle_out());
        chk("midrst_valid", {3'b0, w_valid}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_hold_out", w_out, idle_out());
        @(posedge clk);
        #1;
        chk("release_first_out", w_out, model_out(1, 1'b1));
        chk("release_first_valid", {3'b0, w_valid}, 4'd1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] code;
            logic       e;
            code = 2'($urandom_range(0, 3));
            e    = 1'($urandom_range(0, 1));
            step(code, e, "rand_reg");
        end

        // Combinational instance: no clock edge between stimulus and check.
        @(negedge clk);
        c_en = 1'b1;
        c_in = 2'b00;
        #1;
        chk("comb_00", c_out, model_out(0, 1'b1));
        c_in = 2'b11;
        #1;
        chk("comb_11", c_out, model_out(3, 1'b1));
        chk("comb_11_valid", {3'b0, c_valid}, 4'd1);
        c_en = 1'b0;
        #1;
        chk("comb_dis", c_out, idle_out());
        chk("comb_dis_valid", {3'b0, c_valid}, 4'd0);

        for (int i = 0; i < 20; i++) begin
            c_in = 2'($urandom_range(0, 3));
            c_en = 1'($urandom_range(0, 1));
            #1;
            chk("rand_comb_out", c_out, model_out(int'(c_in), c_en));
            chk("rand_comb_valid", {3'b0, c_valid}, {3'b0, c_en});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
